if_pc_sequencer: RTL and testbench

IF_PC_SEQUENCER -- requirements
Module: if_pc_sequencer

---
 rtl/fetch_pkg.sv | 17 +
 rtl/ifid_pipe_reg.sv | 44 ++++
 rtl/if_pc_sequencer.sv | 122 ++++++++++++
 tb/tb_if_pc_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, default widths, NOP and boot vector.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF         = 16;
  localparam int unsigned INSTR_W_DEF        = 16;
  localparam int unsigned RESET_VEC_ADDR_DEF = 0;
  localparam int unsigned CNT_W              = 16;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: bubble clears to a NOP, load captures the fetch, otherwise holds.
module ifid_pipe_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_plus1_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_plus1_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_plus1_q;
  logic               valid_q;

  // Bubble beats load so a squash can never leak a fetched word into decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else if (bubble_i) begin
      instr_q    <= INSTR_W'(NOP_INSTR);
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus1_q <= pc_plus1_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_pc_sequencer.sv
// Instruction-fetch PC sequencer: boot-vector load, PC update with redirect/halt/stall/flush.
// Optional FETCH_REDIRECT_COUNT_EN adds a saturating redirect_count output.
module if_pc_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned INSTR_W        = INSTR_W_DEF,
  parameter int unsigned RESET_VEC_ADDR = RESET_VEC_ADDR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus1,
  output logic               ifid_valid,
`ifdef FETCH_REDIRECT_COUNT_EN
  output logic [CNT_W-1:0]   redirect_count,
`endif
  output logic               boot_done
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              boot_done_q, boot_done_d;
  logic              ifid_load, ifid_bubble;
`ifdef FETCH_REDIRECT_COUNT_EN
  logic [CNT_W-1:0]  redir_cnt_q;
  logic              redir_inc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= '0;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      boot_done_q <= boot_done_d;
    end
  end

  // Priority in RUN: redirect > halt > stall > normal fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    boot_done_d = boot_done_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
`ifdef FETCH_REDIRECT_COUNT_EN
    redir_inc   = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        pc_d        = ADDR_W'(imem_rdata);
        state_d     = ST_RUN;
        boot_done_d = 1'b1;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          ifid_bubble = 1'b1;
`ifdef FETCH_REDIRECT_COUNT_EN
          redir_inc   = 1'b1;
`endif
        end else if (halt) begin
          state_d     = ST_HALTED;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          ifid_bubble = flush;
        end else begin
          pc_d        = pc_q + ADDR_W'(1);
          ifid_bubble = flush;
          ifid_load   = ~flush;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

`ifdef FETCH_REDIRECT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_cnt_q <= '0;
    end else if (redir_inc && (redir_cnt_q != {CNT_W{1'b1}})) begin
      redir_cnt_q <= redir_cnt_q + CNT_W'(1);
    end
  end

  assign redirect_count = redir_cnt_q;
`endif

  ifid_pipe_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_ifid (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (ifid_load),
    .bubble_i  (ifid_bubble),
    .instr_i   (imem_rdata),
    .pc_plus1_i(pc_q + ADDR_W'(1)),
    .instr_o   (ifid_instr),
    .pc_plus1_o(ifid_pc_plus1),
    .valid_o   (ifid_valid)
  );

  assign imem_addr = (state_q == ST_BOOT) ? ADDR_W'(RESET_VEC_ADDR) : pc_q;
  assign boot_done = boot_done_q;

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Scoreboard bench for if_pc_sequencer: directed scenarios plus random traffic vs a behavioural model.
module tb_if_pc_sequencer;

  localparam logic [15:0] RV      = 16'h0000;
  localparam logic [15:0] BOOT_PC = 16'h0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect_valid, halt;
  logic [15:0] redirect_pc;
  logic [15:0] imem_rdata, imem_addr, ifid_instr, ifid_pc_plus1;
  logic        ifid_valid, boot_done;
`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0] redirect_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pp1;
    logic        valid;
    logic        bdone;
    int          cnt;
  } exp_t;

  exp_t q[$];

  // Behavioural model state: 0 boot, 1 run, 2 halted.
  int          m_phase;
  logic [15:0] m_pc, m_instr, m_pp1;
  logic        m_valid, m_bdone;
  int          m_cnt;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    logic [15:0] t;
    if (a == RV) return BOOT_PC;
    t = a * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  if_pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
`ifdef FETCH_REDIRECT_COUNT_EN
    .redirect_count(redirect_count),
`endif
    .boot_done     (boot_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dut_cnt();
`ifdef FETCH_REDIRECT_COUNT_EN
    return int'(redirect_count);
`else
    return 0;
`endif
  endfunction

  // Monitor: compare DUT outputs after every rising edge that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", 32'(imem_addr), 32'(e.addr));
        chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
        chk("ifid_instr", 32'(ifid_instr), 32'(e.instr));
        if (e.valid) chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(e.pp1));
        chk("boot_done", 32'(boot_done), 32'(e.bdone));
`ifdef FETCH_REDIRECT_COUNT_EN
        chk("redirect_count", 32'(dut_cnt()), 32'(e.cnt));
`endif
      end
    end
  end

  function automatic void model_reset();
    m_phase = 0; m_pc = '0; m_instr = '0; m_pp1 = '0;
    m_valid = 1'b0; m_bdone = 1'b0; m_cnt = 0;
  endfunction

  function automatic void bubble();
    m_valid = 1'b0;
    m_instr = '0;
  endfunction

  // Called at a falling edge: drive inputs, advance model one clock, queue the expectation, wait.
  task automatic cycle(input logic s, input logic f, input logic r, input logic [15:0] rp,
                       input logic h);
    exp_t e;
    stall = s; flush = f; redirect_valid = r; redirect_pc = rp; halt = h;
    case (m_phase)
      0: begin
        m_pc = mem_f(RV); m_phase = 1; m_bdone = 1'b1;
      end
      1: begin
        if (r) begin
          m_pc = rp; bubble();
          if (m_cnt < 65535) m_cnt++;
        end else if (h) begin
          m_phase = 2; bubble();
        end else if (s) begin
          if (f) bubble();
        end else begin
          if (f) bubble();
          else begin
            m_instr = mem_f(m_pc); m_pp1 = m_pc + 16'd1; m_valid = 1'b1;
          end
          m_pc = m_pc + 16'd1;
        end
      end
      default: ;
    endcase
    e.addr = (m_phase == 0) ? RV : m_pc;
    e.instr = m_instr; e.pp1 = m_pp1; e.valid = m_valid; e.bdone = m_bdone; e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Called at a falling edge: asynchronous reset, check reset values, release.
  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("rst imem_addr", 32'(imem_addr), 32'(RV));
    chk("rst ifid_valid", 32'(ifid_valid), 32'd0);
    chk("rst ifid_instr", 32'(ifid_instr), 32'd0);
    chk("rst ifid_pc_plus1", 32'(ifid_pc_plus1), 32'd0);
    chk("rst boot_done", 32'(boot_done), 32'd0);
    chk("rst redirect_count", 32'(dut_cnt()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot imem_addr", 32'(imem_addr), 32'(RV));
  endtask

  initial begin
    logic        s, f, r, h;
    logic [15:0] rp;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    redirect_pc = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Boot vector load, then first fetches.
    idle(6);
    // Two-cycle stall at PC 0x0045, combined with a flush on the second.
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(2);
    // Flush alone still advances PC.
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(1);
    // Redirect with stall and flush in the same cycle.
    cycle(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0);
    idle(2);
    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    idle(3);
    // Redirect beats halt; then halt; then everything ignored.
    cycle(1'b0, 1'b0, 1'b1, 16'h0200, 1'b1);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 16'h0300, 1'b0);
    idle(2);
    // Mid-run reset, inputs active during BOOT must be ignored.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 16'h0500, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 16'(16'h0600 + i * 16), 1'b0);
      idle(1);
    end
    idle(1);
    @(negedge clk);
    do_reset();
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ((m_phase == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        s = ($urandom_range(0, 4) == 0);
        f = ($urandom_range(0, 9) == 0);
        r = ($urandom_range(0, 9) == 0);
        h = ($urandom_range(0, 39) == 0);
        case ($urandom_range(0, 3))
          0: rp = 16'hFFFF;
          1: rp = 16'hFFFE;
          default: rp = 16'($urandom);
        endcase
        cycle(s, f, r, rp, h);
      end
    end

    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
